// File: rtl/adder_counter.sv
// Parametrised up/down accumulator with programmable step, load/clear, and wrap or saturate.
// Provides sticky overflow/underflow flags, a one-cycle boundary pulse and a registered threshold flag.
module adder_counter #(
    parameter int               WIDTH     = 8,
    parameter int               STEP_W    = 4,
    parameter bit               SATURATE  = 1'b0,
    parameter logic [WIDTH-1:0] THRESH    = {WIDTH{1'b1}}
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              clr,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              inc,
    input  logic              dec,
    input  logic [STEP_W-1:0] step,
    output logic [WIDTH-1:0]  out,
    output logic              bnd,
    output logic              ovf,
    output logic              unf,
    output logic              thr_hit
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_out;
    logic             next_bnd;
    logic             next_ovf;
    logic             next_unf;

    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum      = {1'b0, out} + step_ext;
    // The extra top bit of the difference is the borrow, i.e. out < step.
    assign diff     = {1'b0, out} - step_ext;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    always_comb begin
        next_out = out;
        next_bnd = 1'b0;
        next_ovf = ovf;
        next_unf = unf;

        if (clr) begin
            next_out = '0;
            next_ovf = 1'b0;
            next_unf = 1'b0;
        end else if (load) begin
            next_out = load_val;
        end else if (inc && !dec) begin
            if (sum[WIDTH]) begin
                next_bnd = 1'b1;
                next_ovf = 1'b1;
                next_out = SATURATE ? MAX_VAL : sum[WIDTH-1:0];
            end else begin
                next_out = sum[WIDTH-1:0];
            end
        end else if (dec && !inc) begin
            if (diff[WIDTH]) begin
                next_bnd = 1'b1;
                next_unf = 1'b1;
                next_out = SATURATE ? '0 : diff[WIDTH-1:0];
            end else begin
                next_out = diff[WIDTH-1:0];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the combinational block above uses blocking ones.
    always_ff @(posedge aclk) begin
        if (arst) begin
            out     <= '0;
            bnd     <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            thr_hit <= (THRESH == '0);
        end else begin
            out     <= next_out;
            bnd     <= next_bnd;
            ovf     <= next_ovf;
            unf     <= next_unf;
            // Compared against the next value so the flag lines up with out.
            thr_hit <= (next_out == THRESH);
        end
    end

endmodule
